// File: rtl/mem_arbiter_pkg.sv
// Shared bus types and widths for the processor-memory arbiter.
// Includes the command and size encodings and the requester identity.
package mem_arbiter_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned TAG_W     = 4;
  localparam int unsigned TAG_SPACE = 16;
  localparam int unsigned CNT_W     = 5;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_t;

  typedef enum logic [1:0] {
    BYTE   = 2'h0,
    HALF   = 2'h1,
    WORD   = 2'h2,
    DOUBLE = 2'h3
  } mem_size_t;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter, bundled for port lists.
// The arbiter uses slave; the caches/memory environment uses master.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  bus_command_t     ic2arb_command;
  logic [XLEN-1:0]  ic2arb_addr;
  logic [63:0]      ic2arb_data;
  mem_size_t        ic2arb_size;
  bus_command_t     dc2arb_command;
  logic [XLEN-1:0]  dc2arb_addr;
  logic [63:0]      dc2arb_data;
  mem_size_t        dc2arb_size;

  logic [TAG_W-1:0] arb2ic_response;
  logic [63:0]      arb2ic_data;
  logic [TAG_W-1:0] arb2ic_tag;
  logic [TAG_W-1:0] arb2dc_response;
  logic [63:0]      arb2dc_data;
  logic [TAG_W-1:0] arb2dc_tag;

  bus_command_t     proc2mem_command;
  logic [XLEN-1:0]  proc2mem_addr;
  logic [63:0]      proc2mem_data;
  mem_size_t        proc2mem_size;
  logic [TAG_W-1:0] mem2proc_response;
  logic [63:0]      mem2proc_data;
  logic [TAG_W-1:0] mem2proc_tag;

  logic [CNT_W-1:0] arb_outstanding;
  logic             arb_tag_error;

  modport slave (
    input  ic2arb_command, ic2arb_addr, ic2arb_data, ic2arb_size,
    input  dc2arb_command, dc2arb_addr, dc2arb_data, dc2arb_size,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output arb2ic_response, arb2ic_data, arb2ic_tag,
    output arb2dc_response, arb2dc_data, arb2dc_tag,
    output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
    output arb_outstanding, arb_tag_error
  );

  modport master (
    output ic2arb_command, ic2arb_addr, ic2arb_data, ic2arb_size,
    output dc2arb_command, dc2arb_addr, dc2arb_data, dc2arb_size,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  arb2ic_response, arb2ic_data, arb2ic_tag,
    input  arb2dc_response, arb2dc_data, arb2dc_tag,
    input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
    input  arb_outstanding, arb_tag_error
  );

endinterface

// File: rtl/mem_tag_table.sv
// Tracks which requester owns each outstanding load tag.
// A same-cycle set of the returning tag overrides its clear; the lookup uses the old owner.
import mem_arbiter_pkg::*;

module mem_tag_table #(
  parameter int unsigned NUM_TAGS = TAG_SPACE
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             set_en,
  input  logic [TAG_W-1:0] set_tag,
  input  req_id_t          set_owner,
  input  logic [TAG_W-1:0] ret_tag,
  output logic             ret_hit,
  output req_id_t          ret_owner,
  output logic [CNT_W-1:0] outstanding
);

  logic [NUM_TAGS-1:0] pending_q, pending_d;
  req_id_t             owner_q [NUM_TAGS];
  req_id_t             owner_d [NUM_TAGS];

  always_comb begin
    ret_hit   = (ret_tag != '0) && pending_q[ret_tag];
    ret_owner = owner_q[ret_tag];
    pending_d = pending_q;
    owner_d   = owner_q;
    if (ret_hit) pending_d[ret_tag] = 1'b0;
    if (set_en) begin
      pending_d[set_tag] = 1'b1;
      owner_d[set_tag]   = set_owner;
    end
    outstanding = '0;
    for (int unsigned i = 0; i < NUM_TAGS; i++) begin
      outstanding = outstanding + CNT_W'(pending_q[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q <= '0;
      for (int unsigned i = 0; i < NUM_TAGS; i++) owner_q[i] <= REQ_IC;
    end else begin
      pending_q <= pending_d;
      owner_q   <= owner_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the memory port between I-cache and D-cache with D-cache priority and
// bounded I-cache starvation; routes returning load data to the tag's owner.
import mem_arbiter_pkg::*;

module mem_arbiter #(
  parameter int unsigned MAX_STARVE = 4,
  parameter int unsigned NUM_TAGS   = 16
) (
  input logic         clock,
  input logic         reset,
  mem_arbiter_if.slave bus
);

  localparam int unsigned STARVE_W = $clog2(MAX_STARVE + 1);

  logic                ic_act, dc_act, grant_ic, grant_dc, accepted, load_set;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                tag_error_q, tag_error_d;
  logic                ret_hit;
  req_id_t             ret_owner, set_owner;
  logic [CNT_W-1:0]    outstanding;

  mem_tag_table #(.NUM_TAGS(NUM_TAGS)) u_tag_table (
    .clock       (clock),
    .reset       (reset),
    .set_en      (load_set),
    .set_tag     (bus.mem2proc_response),
    .set_owner   (set_owner),
    .ret_tag     (bus.mem2proc_tag),
    .ret_hit     (ret_hit),
    .ret_owner   (ret_owner),
    .outstanding (outstanding)
  );

  always_comb begin
    ic_act   = bus.ic2arb_command != BUS_NONE;
    dc_act   = bus.dc2arb_command != BUS_NONE;
    grant_dc = dc_act && !(ic_act && starve_q == STARVE_W'(MAX_STARVE));
    grant_ic = ic_act && !grant_dc;

    bus.proc2mem_command = BUS_NONE;
    bus.proc2mem_addr    = '0;
    bus.proc2mem_data    = '0;
    bus.proc2mem_size    = BYTE;
    if (grant_dc) begin
      bus.proc2mem_command = bus.dc2arb_command;
      bus.proc2mem_addr    = bus.dc2arb_addr;
      bus.proc2mem_data    = bus.dc2arb_data;
      bus.proc2mem_size    = bus.dc2arb_size;
    end else if (grant_ic) begin
      bus.proc2mem_command = bus.ic2arb_command;
      bus.proc2mem_addr    = bus.ic2arb_addr;
      bus.proc2mem_data    = bus.ic2arb_data;
      bus.proc2mem_size    = bus.ic2arb_size;
    end

    accepted  = (grant_ic || grant_dc) && (bus.mem2proc_response != '0);
    load_set  = accepted && (bus.proc2mem_command == BUS_LOAD);
    set_owner = grant_dc ? REQ_DC : REQ_IC;

    // Starvation only counts D-cache wins that actually beat a waiting I-cache.
    starve_d = starve_q;
    if (accepted && grant_ic) begin
      starve_d = '0;
    end else if (accepted && ic_act && starve_q != STARVE_W'(MAX_STARVE)) begin
      starve_d = starve_q + STARVE_W'(1);
    end
    tag_error_d = tag_error_q || ((bus.mem2proc_tag != '0) && !ret_hit);

    bus.arb2ic_response = grant_ic ? bus.mem2proc_response : '0;
    bus.arb2dc_response = grant_dc ? bus.mem2proc_response : '0;
    bus.arb2ic_tag      = (ret_hit && ret_owner == REQ_IC) ? bus.mem2proc_tag : '0;
    bus.arb2dc_tag      = (ret_hit && ret_owner == REQ_DC) ? bus.mem2proc_tag : '0;
    bus.arb2ic_data     = bus.mem2proc_data;
    bus.arb2dc_data     = bus.mem2proc_data;
    bus.arb_outstanding = outstanding;
    bus.arb_tag_error   = tag_error_q;

    if (reset) begin
      bus.proc2mem_command = BUS_NONE;
      bus.proc2mem_addr    = '0;
      bus.proc2mem_data    = '0;
      bus.proc2mem_size    = BYTE;
      bus.arb2ic_response  = '0;
      bus.arb2dc_response  = '0;
      bus.arb2ic_tag       = '0;
      bus.arb2dc_tag       = '0;
      bus.arb2ic_data      = '0;
      bus.arb2dc_data      = '0;
      bus.arb_outstanding  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q    <= '0;
      tag_error_q <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      tag_error_q <= tag_error_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter: grant, starvation, tag routing,
// spurious returns and reset abandonment.
import mem_arbiter_pkg::*;

module tb_mem_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(.MAX_STARVE(4), .NUM_TAGS(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  ic_cmd;
    logic [31:0] ic_addr;
    logic [1:0]  dc_cmd;
    logic [31:0] dc_addr;
    logic [3:0]  resp;
    logic [3:0]  tag;
    logic [63:0] data;
    logic [1:0]  e_cmd;
    logic [31:0] e_addr;
    logic [63:0] e_wdat;
    logic [3:0]  e_icr;
    logic [3:0]  e_dcr;
    logic [3:0]  e_ict;
    logic [3:0]  e_dct;
    logic [4:0]  e_out;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.ic2arb_command    = bus_command_t'(v.ic_cmd);
    bus.ic2arb_addr       = v.ic_addr;
    bus.dc2arb_command    = bus_command_t'(v.dc_cmd);
    bus.dc2arb_addr       = v.dc_addr;
    bus.mem2proc_response = v.resp;
    bus.mem2proc_tag      = v.tag;
    bus.mem2proc_data     = v.data;
  endtask

  // Inputs change 1 time unit after a rising edge; combinational outputs are
  // sampled mid-cycle, registered outputs 1 unit after the following edge.
  task automatic apply(input string name, input vec_t v);
    drive(v);
    #4;
    check({name, ".cmd"},    64'(bus.proc2mem_command), 64'(v.e_cmd));
    check({name, ".addr"},   64'(bus.proc2mem_addr),    64'(v.e_addr));
    check({name, ".wdata"},  bus.proc2mem_data,         v.e_wdat);
    check({name, ".ic_rsp"}, 64'(bus.arb2ic_response),  64'(v.e_icr));
    check({name, ".dc_rsp"}, 64'(bus.arb2dc_response),  64'(v.e_dcr));
    check({name, ".ic_tag"}, 64'(bus.arb2ic_tag),       64'(v.e_ict));
    check({name, ".dc_tag"}, 64'(bus.arb2dc_tag),       64'(v.e_dct));
    check({name, ".ic_dat"}, bus.arb2ic_data,           v.data);
    check({name, ".dc_dat"}, bus.arb2dc_data,           v.data);
    @(posedge clock);
    #1;
    check({name, ".outst"},  64'(bus.arb_outstanding),  64'(v.e_out));
    check({name, ".err"},    64'(bus.arb_tag_error),    64'(v.e_err));
  endtask

  initial begin
    vec_t v;
    bus.ic2arb_data       = 64'h1111;
    bus.dc2arb_data       = 64'h2222;
    bus.ic2arb_size       = WORD;
    bus.dc2arb_size       = DOUBLE;
    bus.ic2arb_command    = BUS_LOAD;
    bus.ic2arb_addr       = 32'h100;
    bus.dc2arb_command    = BUS_NONE;
    bus.dc2arb_addr       = '0;
    bus.mem2proc_response = 4'd3;
    bus.mem2proc_tag      = 4'd3;
    bus.mem2proc_data     = 64'hBEEF;

    // Reset state: requests and returns present but everything suppressed.
    @(posedge clock);
    #1;
    check("rst.cmd",    64'(bus.proc2mem_command), 64'(BUS_NONE));
    check("rst.ic_rsp", 64'(bus.arb2ic_response),  64'h0);
    check("rst.ic_tag", 64'(bus.arb2ic_tag),       64'h0);
    check("rst.ic_dat", bus.arb2ic_data,           64'h0);
    check("rst.outst",  64'(bus.arb_outstanding),  64'h0);
    @(posedge clock);
    #1;
    check("rst.err",    64'(bus.arb_tag_error),    64'h0);
    reset = 1'b0;

    //            ic  ic_addr  dc  dc_addr  rsp tag data     cmd addr     wdat     icr dcr ict dct out err
    vecs.push_back('{1, 'h100, 0, 'h000,  3, 0, 'h0,     1, 'h100, 'h1111, 3, 0, 0, 0, 1, 0});
    vecs.push_back('{0, 'h000, 0, 'h000,  0, 3, 'hDEAD,  0, 'h000, 'h0,    0, 0, 3, 0, 0, 0});
    vecs.push_back('{1, 'h200, 1, 'h300,  1, 0, 'h0,     1, 'h300, 'h2222, 0, 1, 0, 0, 1, 0});
    vecs.push_back('{1, 'h200, 1, 'h300,  2, 0, 'h0,     1, 'h300, 'h2222, 0, 2, 0, 0, 2, 0});
    vecs.push_back('{1, 'h200, 1, 'h300,  0, 0, 'h0,     1, 'h300, 'h2222, 0, 0, 0, 0, 2, 0});
    vecs.push_back('{1, 'h200, 1, 'h300,  0, 0, 'h0,     1, 'h300, 'h2222, 0, 0, 0, 0, 2, 0});
    vecs.push_back('{1, 'h200, 1, 'h300,  0, 0, 'h0,     1, 'h300, 'h2222, 0, 0, 0, 0, 2, 0});
    vecs.push_back('{1, 'h200, 1, 'h300,  3, 0, 'h0,     1, 'h300, 'h2222, 0, 3, 0, 0, 3, 0});
    vecs.push_back('{1, 'h200, 1, 'h300,  4, 0, 'h0,     1, 'h300, 'h2222, 0, 4, 0, 0, 4, 0});
    vecs.push_back('{1, 'h200, 1, 'h300,  6, 0, 'h0,     1, 'h200, 'h1111, 6, 0, 0, 0, 5, 0});
    vecs.push_back('{1, 'h200, 1, 'h300,  7, 0, 'h0,     1, 'h300, 'h2222, 0, 7, 0, 0, 6, 0});
    vecs.push_back('{0, 'h000, 0, 'h000,  0, 1, 'hA1,    0, 'h000, 'h0,    0, 0, 0, 1, 5, 0});
    vecs.push_back('{0, 'h000, 0, 'h000,  0, 6, 'hA6,    0, 'h000, 'h0,    0, 0, 6, 0, 4, 0});
    vecs.push_back('{0, 'h000, 2, 'h400,  5, 0, 'h0,     2, 'h400, 'h2222, 0, 5, 0, 0, 4, 0});
    vecs.push_back('{0, 'h000, 0, 'h000,  0, 5, 'hA5,    0, 'h000, 'h0,    0, 0, 0, 0, 4, 1});
    vecs.push_back('{0, 'h000, 0, 'h000,  0, 2, 'hA2,    0, 'h000, 'h0,    0, 0, 0, 2, 3, 1});
    vecs.push_back('{0, 'h000, 0, 'h000,  0, 7, 'hA7,    0, 'h000, 'h0,    0, 0, 0, 7, 2, 1});

    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

    // Tag 7 returns to its I-cache owner while being re-issued to the D-cache.
    v = '{1, 'h500, 0, 'h000, 7, 0, 'h0,   1, 'h500, 'h1111, 7, 0, 0, 0, 3, 1};
    apply("reuse.alloc", v);
    v = '{0, 'h000, 1, 'h600, 7, 7, 'hB7,  1, 'h600, 'h2222, 0, 7, 7, 0, 3, 1};
    apply("reuse.swap", v);
    v = '{0, 'h000, 0, 'h000, 0, 7, 'hC7,  0, 'h000, 'h0,    0, 0, 0, 7, 2, 1};
    apply("reuse.ret", v);

    // Third load pending, then a one-cycle reset abandons tags 3, 4 and 10.
    v = '{1, 'h700, 0, 'h000, 10, 0, 'h0,  1, 'h700, 'h1111, 10, 0, 0, 0, 3, 1};
    apply("abandon.alloc", v);
    v = '{1, 'h800, 0, 'h000, 3, 4, 'hD4,  0, 'h000, 'h0,    0, 0, 0, 0, 0, 0};
    drive(v);
    reset = 1'b1;
    #4;
    check("abandon.rst_cmd",   64'(bus.proc2mem_command), 64'(BUS_NONE));
    check("abandon.rst_icrsp", 64'(bus.arb2ic_response),  64'h0);
    check("abandon.rst_dctag", 64'(bus.arb2dc_tag),       64'h0);
    check("abandon.rst_outst", 64'(bus.arb_outstanding),  64'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("abandon.outst",     64'(bus.arb_outstanding),  64'h0);
    check("abandon.err_clr",   64'(bus.arb_tag_error),    64'h0);
    v = '{0, 'h000, 0, 'h000, 0, 3, 'hE3,  0, 'h000, 'h0,    0, 0, 0, 0, 0, 1};
    apply("abandon.ret", v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
